// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between CPU (port 0) and loader (port 1).
// Optional range check on latched addresses is enabled by defining DM_ARB_RANGE_CHK_EN.
module dm_arbiter #(
   parameter logic [31:0] ADDR_MAX = 32'h00002fff,
   parameter int          RR_RESET = 0
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        P0_Req,
   input  logic [31:0] P0_Ad,
   input  logic [31:0] P0_Wd,
   input  logic        P0_Wr,
   input  logic [3:0]  P0_Be,
   input  logic [31:0] P0_Pc,
   output logic        P0_Ack,
   output logic [31:0] P0_Rd,
   input  logic        P1_Req,
   input  logic [31:0] P1_Ad,
   input  logic [31:0] P1_Wd,
   input  logic        P1_Wr,
   input  logic [3:0]  P1_Be,
   input  logic [31:0] P1_Pc,
   output logic        P1_Ack,
   output logic [31:0] P1_Rd,
   output logic [31:0] M_Ad,
   output logic [31:0] M_Wd,
   output logic        M_Wr,
   output logic [31:0] M_Pc,
   input  logic [31:0] M_Rd,
   output logic        Err,
   output logic [1:0]  dbg_state
);

`ifdef DM_ARB_RANGE_CHK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, MRG = 2'd2, RESP = 2'd3} state_t;

   state_t      state;
   logic        gnt;
   logic        ptr;
   logic        wr_q;
   logic [3:0]  be_q;
   logic [31:0] wd_q;
   logic        bad_q;
   logic        ack0_q;
   logic        ack1_q;
   logic        err_q;
   logic [31:0] rd_q;

   logic        any_req;
   logic        sel;
   logic [31:0] sel_ad;
   logic [31:0] sel_wd;
   logic [31:0] sel_pc;
   logic        sel_wr;
   logic [3:0]  sel_be;
   logic        bad_next;
   logic [31:0] merged;

   // On contention the pointer names the favoured port; a lone requester always wins.
   always_comb begin
      any_req  = P0_Req | P1_Req;
      sel      = (P0_Req && P1_Req) ? ptr : P1_Req;
      sel_ad   = sel ? P1_Ad : P0_Ad;
      sel_wd   = sel ? P1_Wd : P0_Wd;
      sel_pc   = sel ? P1_Pc : P0_Pc;
      sel_wr   = sel ? P1_Wr : P0_Wr;
      sel_be   = sel ? P1_Be : P0_Be;
      bad_next = RANGE_EN && (sel_ad > ADDR_MAX);
   end

   always_comb begin
      merged = M_Rd;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged[8*i +: 8] = wd_q[8*i +: 8];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= IDLE;
         ptr    <= (RR_RESET != 0);
         gnt    <= 1'b0;
         wr_q   <= 1'b0;
         be_q   <= 4'h0;
         wd_q   <= 32'h0;
         bad_q  <= 1'b0;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err_q  <= 1'b0;
         rd_q   <= 32'h0;
         M_Ad   <= 32'h0;
         M_Wd   <= 32'h0;
         M_Wr   <= 1'b0;
         M_Pc   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt   <= sel;
                  ptr   <= ~sel;
                  wr_q  <= sel_wr;
                  be_q  <= sel_be;
                  wd_q  <= sel_wd;
                  bad_q <= bad_next;
                  M_Ad  <= {sel_ad[31:2], 2'b00};
                  M_Pc  <= sel_pc;
                  // A full-word store writes straight away during ACC.
                  M_Wr  <= sel_wr && (sel_be == 4'hF) && !bad_next;
                  M_Wd  <= (sel_wr && (sel_be == 4'hF)) ? sel_wd : 32'h0;
                  state <= ACC;
               end
            end
            ACC: begin
               if (wr_q && (be_q != 4'hF) && (be_q != 4'h0)) begin
                  M_Wr  <= !bad_q;
                  M_Wd  <= merged;
                  state <= MRG;
               end else begin
                  M_Wr   <= 1'b0;
                  ack0_q <= !gnt;
                  ack1_q <= gnt;
                  err_q  <= bad_q;
                  rd_q   <= (!wr_q && !bad_q) ? M_Rd : 32'h0;
                  state  <= RESP;
               end
            end
            MRG: begin
               M_Wr   <= 1'b0;
               ack0_q <= !gnt;
               ack1_q <= gnt;
               err_q  <= bad_q;
               rd_q   <= 32'h0;
               state  <= RESP;
            end
            RESP: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               err_q  <= 1'b0;
               rd_q   <= 32'h0;
               M_Ad   <= 32'h0;
               M_Wd   <= 32'h0;
               M_Pc   <= 32'h0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign P0_Ack    = ack0_q;
   assign P1_Ack    = ack1_q;
   assign P0_Rd     = gnt ? 32'h0 : rd_q;
   assign P1_Rd     = gnt ? rd_q : 32'h0;
   assign Err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized two-port traffic against a word-level model.
// Handshake: a port holds Req and its fields stable until it sees Ack; Ack is a one-cycle pulse.
module tb_dm_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        P0_Req = 0, P1_Req = 0;
   logic [31:0] P0_Ad = 0, P1_Ad = 0, P0_Wd = 0, P1_Wd = 0, P0_Pc = 0, P1_Pc = 0;
   logic        P0_Wr = 0, P1_Wr = 0;
   logic [3:0]  P0_Be = 0, P1_Be = 0;
   logic        P0_Ack, P1_Ack, M_Wr, Err;
   logic [31:0] P0_Rd, P1_Rd, M_Ad, M_Wd, M_Pc, M_Rd;
   logic [1:0]  dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] mem [0:4095];
   logic [31:0] ref_mem [0:15];

   always #5 Clk = ~Clk;

   assign M_Rd = mem[M_Ad[13:2]];
   always @(posedge Clk) if (M_Wr) mem[M_Ad[13:2]] <= M_Wd;

   dm_arbiter dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .P0_Req(P0_Req), .P0_Ad(P0_Ad), .P0_Wd(P0_Wd), .P0_Wr(P0_Wr), .P0_Be(P0_Be), .P0_Pc(P0_Pc),
      .P0_Ack(P0_Ack), .P0_Rd(P0_Rd),
      .P1_Req(P1_Req), .P1_Ad(P1_Ad), .P1_Wd(P1_Wd), .P1_Wr(P1_Wr), .P1_Be(P1_Be), .P1_Pc(P1_Pc),
      .P1_Ack(P1_Ack), .P1_Rd(P1_Rd),
      .M_Ad(M_Ad), .M_Wd(M_Wd), .M_Wr(M_Wr), .M_Pc(M_Pc), .M_Rd(M_Rd),
      .Err(Err), .dbg_state(dbg_state)
   );

   task automatic set_port(input int p, input logic req, input logic wr, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] pc);
      if (p == 0) begin
         P0_Req = req; P0_Wr = wr; P0_Ad = ad; P0_Wd = wd; P0_Be = be; P0_Pc = pc;
      end else begin
         P1_Req = req; P1_Wr = wr; P1_Ad = ad; P1_Wd = wd; P1_Be = be; P1_Pc = pc;
      end
   endtask

   task automatic apply_reset();
      Reset_n = 1'b0;
      P0_Req = 1'b0;
      P1_Req = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   // Drives one access and reports latency (negedges after the sample edge), M_Wr activity and response.
   task automatic run_access(input int p, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                             input logic [3:0] be, output int lat, output logic [31:0] rd,
                             output int wr_cnt, output logic [31:0] wd_seen, output logic err_seen,
                             output logic other_ack);
      @(negedge Clk);
      set_port(p, 1'b1, wr, ad, wd, be, 32'h100 + ad);
      lat = -1; rd = 32'hx; wr_cnt = 0; wd_seen = 32'h0; err_seen = 1'b0; other_ack = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if (M_Wr) begin
            wr_cnt++;
            wd_seen = M_Wd;
         end
         if ((p == 0 ? P1_Ack : P0_Ack)) other_ack = 1'b1;
         if ((p == 0 ? P0_Ack : P1_Ack)) begin
            lat = c;
            rd = (p == 0) ? P0_Rd : P1_Rd;
            err_seen = Err;
            set_port(p, 1'b0, wr, ad, wd, be, 32'h0);
            break;
         end
      end
      if (lat < 0) set_port(p, 1'b0, wr, ad, wd, be, 32'h0);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #1;
      tests_run++;
      if ({P0_Ack, P1_Ack, M_Wr, Err} !== 4'b0) begin
         tests_failed++; $display("FAIL reset_flags got=%b exp=0000", {P0_Ack, P1_Ack, M_Wr, Err});
      end
      tests_run++;
      if (M_Ad !== 32'h0 || M_Wd !== 32'h0 || M_Pc !== 32'h0) begin
         tests_failed++; $display("FAIL reset_mem_bus got ad=%h wd=%h pc=%h exp=0", M_Ad, M_Wd, M_Pc);
      end
      tests_run++;
      if (P0_Rd !== 32'h0 || P1_Rd !== 32'h0) begin
         tests_failed++; $display("FAIL reset_rd got p0=%h p1=%h exp=0", P0_Rd, P1_Rd);
      end
      tests_run++;
      if (dbg_state !== 2'd0) begin
         tests_failed++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
      end
      apply_reset();
   endtask

   task automatic test_load();
      int lat, wc; logic [31:0] rd, wds; logic e, oa;
      @(negedge Clk);
      mem[32'h10 >> 2] <= 32'hDEADBEEF;
      run_access(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, wc, wds, e, oa);
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL load_latency got=%0d exp=2", lat); end
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rd got=%h exp=deadbeef", rd); end
      tests_run++;
      if (wc !== 0 || oa !== 1'b0) begin
         tests_failed++; $display("FAIL load_side_effects got wr=%0d other_ack=%b exp 0 0", wc, oa);
      end
   endtask

   task automatic test_partial_store();
      int lat, wc; logic [31:0] rd, wds; logic e, oa;
      @(negedge Clk);
      mem[32'h20 >> 2] <= 32'h11223344;
      run_access(1, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, lat, rd, wc, wds, e, oa);
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL pstore_latency got=%0d exp=3", lat); end
      tests_run++;
      if (wc !== 1) begin tests_failed++; $display("FAIL pstore_wr_pulses got=%0d exp=1", wc); end
      tests_run++;
      if (wds !== 32'h1122AB44) begin tests_failed++; $display("FAIL pstore_wd got=%h exp=1122ab44", wds); end
      tests_run++;
      if (rd !== 32'h0 || oa !== 1'b0) begin
         tests_failed++; $display("FAIL pstore_resp got rd=%h other_ack=%b exp 0 0", rd, oa);
      end
      @(negedge Clk);
      tests_run++;
      if (mem[32'h20 >> 2] !== 32'h1122AB44) begin
         tests_failed++; $display("FAIL pstore_mem got=%h exp=1122ab44", mem[32'h20 >> 2]);
      end
   endtask

   task automatic test_noop_store();
      int lat, wc; logic [31:0] rd, wds; logic e, oa;
      @(negedge Clk);
      mem[32'h30 >> 2] <= 32'hCAFEF00D;
      run_access(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, lat, rd, wc, wds, e, oa);
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL noop_latency got=%0d exp=2", lat); end
      tests_run++;
      if (wc !== 0) begin tests_failed++; $display("FAIL noop_wr got=%0d exp=0", wc); end
      tests_run++;
      if (mem[32'h30 >> 2] !== 32'hCAFEF00D) begin
         tests_failed++; $display("FAIL noop_mem got=%h exp=cafef00d", mem[32'h30 >> 2]);
      end
   endtask

   task automatic test_full_store();
      int lat, wc; logic [31:0] rd, wds; logic e, oa;
      run_access(1, 1'b1, 32'h37, 32'h5A5AA5A5, 4'hF, lat, rd, wc, wds, e, oa);
      @(negedge Clk);
      tests_run++;
      if (lat !== 2 || wc !== 1 || mem[32'h34 >> 2] !== 32'h5A5AA5A5) begin
         tests_failed++;
         $display("FAIL full_store got lat=%0d wr=%0d mem=%h exp 2 1 5a5aa5a5", lat, wc, mem[32'h34 >> 2]);
      end
   endtask

   task automatic test_contention();
      int order[4];
      int n = 0;
      logic prev0 = 1'b0, prev1 = 1'b0;
      logic wide = 1'b0;
      apply_reset();
      set_port(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hA0);
      set_port(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 32'hA4);
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge Clk);
         if ((P0_Ack && prev0) || (P1_Ack && prev1)) wide = 1'b1;
         if (P0_Ack && !prev0) begin order[n] = 0; n++; end
         if (P1_Ack && !prev1 && n < 4) begin order[n] = 1; n++; end
         prev0 = P0_Ack;
         prev1 = P1_Ack;
      end
      P0_Req = 1'b0;
      P1_Req = 1'b0;
      @(negedge Clk);
      if ((P0_Ack && prev0) || (P1_Ack && prev1)) wide = 1'b1;
      tests_run++;
      if (n !== 4) begin tests_failed++; $display("FAIL contention_count got=%0d exp=4", n); end
      for (int i = 0; i < n; i++) begin
         tests_run++;
         if (order[i] !== (i % 2)) begin
            tests_failed++; $display("FAIL contention_order[%0d] got=P%0d exp=P%0d", i, order[i], i % 2);
         end
      end
      tests_run++;
      if (wide !== 1'b0) begin tests_failed++; $display("FAIL contention_ack_width got=wide exp=one_cycle"); end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      logic acked = 1'b0;
      @(negedge Clk);
      mem[32'h50 >> 2] <= 32'h01020304;
      @(negedge Clk);
      set_port(0, 1'b1, 1'b1, 32'h50, 32'hFFFFFFFF, 4'b1001, 32'h77);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         if (M_Wr) begin seen = 1'b1; break; end
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL rmid_reach_mrg got=no_write exp=write_pulse"); end
      Reset_n = 1'b0;
      P0_Req = 1'b0;
      #1;
      tests_run++;
      if (M_Wr !== 1'b0 || dbg_state !== 2'd0) begin
         tests_failed++; $display("FAIL rmid_async got wr=%b state=%0d exp 0 0", M_Wr, dbg_state);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         if (P0_Ack || P1_Ack) acked = 1'b1;
      end
      tests_run++;
      if (acked) begin tests_failed++; $display("FAIL rmid_ack got=ack exp=none"); end
      tests_run++;
      if (mem[32'h50 >> 2] !== 32'h01020304) begin
         tests_failed++; $display("FAIL rmid_mem got=%h exp=01020304", mem[32'h50 >> 2]);
      end
      tests_run++;
      if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rmid_state got=%0d exp=0", dbg_state); end
   endtask

`ifdef DM_ARB_RANGE_CHK_EN
   task automatic test_range();
      int lat, wc; logic [31:0] rd, wds; logic e, oa;
      run_access(0, 1'b1, 32'h3000, 32'h12345678, 4'hF, lat, rd, wc, wds, e, oa);
      tests_run++;
      if (wc !== 0 || e !== 1'b1 || lat !== 2) begin
         tests_failed++; $display("FAIL range_chk got wr=%0d err=%b lat=%0d exp 0 1 2", wc, e, lat);
      end
   endtask
`endif

   // Reference: each port has one access outstanding; completions apply to a word array in Ack order.
   task automatic test_random();
      logic        act[2];
      logic        r_wr[2];
      logic [31:0] r_ad[2], r_wd[2], r_pc[2];
      logic [3:0]  r_be[2];
      int          waits[2];
      int          done = 0;
      logic [31:0] exp_rd, w;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         ref_mem[i] = w;
         mem[i] <= w;
      end
      act[0] = 1'b0; act[1] = 1'b0;
      waits[0] = 0; waits[1] = 0;
      for (int c = 0; c < 4000 && (done < 80 || act[0] || act[1]); c++) begin
         @(negedge Clk);
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? P0_Ack : P1_Ack) begin
               exp_rd = r_wr[p] ? 32'h0 : ref_mem[r_ad[p][5:2]];
               tests_run++;
               if (!act[p] || ((p == 0) ? P0_Rd : P1_Rd) !== exp_rd || Err !== 1'b0 || M_Pc !== r_pc[p]) begin
                  tests_failed++;
                  $display("FAIL rand_resp P%0d got rd=%h err=%b pc=%h exp rd=%h err=0 pc=%h", p,
                           (p == 0) ? P0_Rd : P1_Rd, Err, M_Pc, exp_rd, r_pc[p]);
               end
               tests_run++;
               if (waits[p] > 1) begin
                  tests_failed++; $display("FAIL rand_fair P%0d got waits=%0d exp<=1", p, waits[p]);
               end
               if (r_wr[p]) begin
                  w = ref_mem[r_ad[p][5:2]];
                  for (int b = 0; b < 4; b++) if (r_be[p][b]) w[8*b +: 8] = r_wd[p][8*b +: 8];
                  ref_mem[r_ad[p][5:2]] = w;
               end
               if (act[1-p]) waits[1-p]++;
               act[p] = 1'b0;
               set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
               done++;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && done < 80 && $urandom_range(1, 0) == 1) begin
               act[p] = 1'b1;
               waits[p] = 0;
               r_wr[p] = 1'($urandom_range(1, 0));
               r_ad[p] = 32'($urandom_range(63, 0));
               r_wd[p] = $urandom;
               r_be[p] = 4'($urandom_range(15, 0));
               r_pc[p] = $urandom;
               set_port(p, 1'b1, r_wr[p], r_ad[p], r_wd[p], r_be[p], r_pc[p]);
            end
         end
      end
      tests_run++;
      if (act[0] || act[1] || done < 80) begin
         tests_failed++; $display("FAIL rand_timeout got done=%0d exp=80 with none pending", done);
      end
      @(negedge Clk);
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (mem[i] !== ref_mem[i]) begin
            tests_failed++; $display("FAIL rand_mem[%0d] got=%h exp=%h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      test_reset();
      test_load();
      test_partial_store();
      test_noop_store();
      test_full_store();
      test_contention();
      test_reset_mid();
`ifdef DM_ARB_RANGE_CHK_EN
      test_range();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
